// File: rtl/exception_unit.sv
// Exception unit: fixed-priority capture, timed flush, handler redirect, ERET return.
// Optional EXC_MASK_EN macro adds a per-source enable mask input.
module exception_unit #(
  parameter int          NUM_SRC      = 5,
  parameter int          PC_W         = 32,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  localparam int         CAUSE_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] exc_req,
  input  logic [PC_W-1:0]    exc_pc,
`ifdef EXC_MASK_EN
  input  logic [NUM_SRC-1:0] exc_mask,
`endif
  input  logic               eret,
  output logic               flush,
  output logic               pc_redirect,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               exl,
  output logic               exc_lost
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    HANDLER
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [NUM_SRC-1:0]   req;
  logic [CAUSE_W-1:0]   idx;
  logic                 any;

  localparam logic [PC_W-1:0] HANDLER_PC = PC_W'(HANDLER_ADDR);
  localparam logic [3:0]      CNT_INIT   = 4'(FLUSH_CYCLES - 1);

`ifdef EXC_MASK_EN
  assign req = exc_req & exc_mask;
`else
  assign req = exc_req;
`endif

  assign any = |req;

  // Lowest set bit of the effective request vector wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = CAUSE_W'(i);
    end
  end

  // Exception state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      flush       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      epc         <= '0;
      cause       <= '0;
      exl         <= 1'b0;
      exc_lost    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pc_redirect <= 1'b0;
          if (any) begin
            cause <= idx;
            epc   <= exc_pc;
            exl   <= 1'b1;
            flush <= 1'b1;
            cnt   <= CNT_INIT;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (any) exc_lost <= 1'b1;
          if (cnt == '0) begin
            flush       <= 1'b0;
            pc_redirect <= 1'b1;
            redirect_pc <= HANDLER_PC;
            state       <= REDIRECT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (any) exc_lost <= 1'b1;
          pc_redirect <= 1'b0;
          state       <= HANDLER;
        end
        HANDLER: begin
          if (eret) begin
            pc_redirect <= 1'b1;
            redirect_pc <= epc;
            exl         <= 1'b0;
            exc_lost    <= 1'b0;
            state       <= IDLE;
          end else if (any) begin
            exc_lost <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with immediate-assertion checks.
// Define EXC_MASK_EN to also exercise the source mask.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  exc_req;
  logic [31:0] exc_pc;
`ifdef EXC_MASK_EN
  logic [4:0]  exc_mask;
`endif
  logic        eret;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [2:0]  cause;
  logic        exl;
  logic        exc_lost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk(clk),
    .rst(rst),
    .exc_req(exc_req),
    .exc_pc(exc_pc),
`ifdef EXC_MASK_EN
    .exc_mask(exc_mask),
`endif
    .eret(eret),
    .flush(flush),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .epc(epc),
    .cause(cause),
    .exl(exl),
    .exc_lost(exc_lost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".flush"}, 32'(flush), 32'd0);
    chk({tag, ".redir"}, 32'(pc_redirect), 32'd0);
    chk({tag, ".exl"}, 32'(exl), 32'd0);
    chk({tag, ".lost"}, 32'(exc_lost), 32'd0);
    chk({tag, ".epc"}, epc, 32'd0);
    chk({tag, ".cause"}, 32'(cause), 32'd0);
    chk({tag, ".rpc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    exc_req = '0;
    exc_pc  = '0;
    eret    = 1'b0;
`ifdef EXC_MASK_EN
    exc_mask = 5'b11111;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("rst0");

    // single request, bit 2
    exc_req = 5'b00100;
    exc_pc  = 32'h0040_0010;
    tick();
    exc_req = '0;
    chk("t2.cause", 32'(cause), 32'd2);
    chk("t2.epc", epc, 32'h0040_0010);
    chk("t2.flush1", 32'(flush), 32'd1);
    chk("t2.exl", 32'(exl), 32'd1);
    chk("t2.redir0", 32'(pc_redirect), 32'd0);
    tick();
    chk("t2.flush2", 32'(flush), 32'd1);
    chk("t2.redir1", 32'(pc_redirect), 32'd0);
    tick();
    chk("t2.flush3", 32'(flush), 32'd0);
    chk("t2.redir", 32'(pc_redirect), 32'd1);
    chk("t2.rpc", redirect_pc, 32'h8000_0180);
    tick();
    chk("t2.redir_off", 32'(pc_redirect), 32'd0);
    chk("t2.exl_h", 32'(exl), 32'd1);

    // nested request in HANDLER is lost
    exc_req = 5'b00001;
    tick();
    exc_req = '0;
    chk("t4.lost", 32'(exc_lost), 32'd1);
    chk("t4.epc", epc, 32'h0040_0010);
    chk("t4.cause", 32'(cause), 32'd2);
    chk("t4.noflush", 32'(flush), 32'd0);
    tick();
    chk("t4.sticky", 32'(exc_lost), 32'd1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("t4.ret", 32'(pc_redirect), 32'd1);
    chk("t4.rpc", redirect_pc, 32'h0040_0010);
    chk("t4.exl", 32'(exl), 32'd0);
    chk("t4.lost0", 32'(exc_lost), 32'd0);
    tick();
    chk("t4.ret_off", 32'(pc_redirect), 32'd0);

    // eret in IDLE is ignored
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("t5.idle_redir", 32'(pc_redirect), 32'd0);
    chk("t5.idle_exl", 32'(exl), 32'd0);

    // multiple requests, eret during FLUSH
    exc_req = 5'b10110;
    exc_pc  = 32'h0000_1234;
    tick();
    exc_req = '0;
    chk("t3.cause", 32'(cause), 32'd1);
    chk("t3.epc", epc, 32'h0000_1234);
    chk("t3.flush1", 32'(flush), 32'd1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("t3.flush2", 32'(flush), 32'd1);
    chk("t3.redir0", 32'(pc_redirect), 32'd0);
    tick();
    chk("t3.flush3", 32'(flush), 32'd0);
    chk("t3.redir", 32'(pc_redirect), 32'd1);
    chk("t3.rpc", redirect_pc, 32'h8000_0180);
    tick();
    chk("t3.redir_off", 32'(pc_redirect), 32'd0);
    chk("t3.exl", 32'(exl), 32'd1);
    tick();
    chk("t3.noflush", 32'(flush), 32'd0);
    chk("t3.noredir", 32'(pc_redirect), 32'd0);

    // eret and exc_req together in HANDLER
    exc_req = 5'b00001;
    tick();
    chk("t5.lost", 32'(exc_lost), 32'd1);
    exc_req = 5'b01000;
    eret    = 1'b1;
    tick();
    eret = 1'b0;
    chk("t5.ret", 32'(pc_redirect), 32'd1);
    chk("t5.rpc", redirect_pc, 32'h0000_1234);
    chk("t5.exl", 32'(exl), 32'd0);
    chk("t5.lost0", 32'(exc_lost), 32'd0);
    chk("t5.cause", 32'(cause), 32'd1);

    // back-to-back accept right after return
    exc_pc = 32'h0000_2000;
    tick();
    exc_req = '0;
    chk("bb.cause", 32'(cause), 32'd3);
    chk("bb.epc", epc, 32'h0000_2000);
    chk("bb.flush", 32'(flush), 32'd1);
    chk("bb.redir_off", 32'(pc_redirect), 32'd0);
    chk("bb.exl", 32'(exl), 32'd1);
    tick();
    tick();
    tick();
    chk("bb.handler", 32'(exl), 32'd1);

    // reset from HANDLER
    exc_req = 5'b00010;
    tick();
    exc_req = '0;
    chk("rst.pre_lost", 32'(exc_lost), 32'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("rst1");
    tick();
    chk("rst.stay", 32'(flush), 32'd0);

`ifdef EXC_MASK_EN
    exc_mask = 5'b11011;
    exc_req  = 5'b00100;
    exc_pc   = 32'h0000_3000;
    tick();
    chk("m.noflush", 32'(flush), 32'd0);
    chk("m.noexl", 32'(exl), 32'd0);
    exc_req = 5'b00110;
    tick();
    exc_req = '0;
    chk("m.cause", 32'(cause), 32'd1);
    chk("m.flush", 32'(flush), 32'd1);
    chk("m.epc", epc, 32'h0000_3000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
Parametrised successor to the single-cycle exception OR gate in the MIPS datapath. It accepts NUM_SRC exception request lines from Control, ALU Control and the ALU flag outputs, and resolves them by fixed priority. On an accepted exception it latches the cause and EPC, drives a multi-cycle pipeline flush, then redirects the PC to the handler. It stays in handler mode until ERET, then redirects back to EPC. It sits beside the PC mux and pipeline registers and replaces the combinational OR.

Parameters:
NUM_SRC, 5, number of exception request lines (1..32); bit 0 has the highest priority.
PC_W, 32, width of the PC, EPC and redirect address.
FLUSH_CYCLES, 2, number of cycles flush is held high (1..15).
HANDLER_ADDR, 32'h8000_0180, handler entry address; truncated to PC_W.
Derived: CAUSE_W = max(1, clog2(NUM_SRC)).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
exc_req  in  NUM_SRC  per-source exception request, level, sampled each clk
exc_pc  in  PC_W  PC of the instruction raising the exception, sampled with exc_req
eret  in  1  return-from-exception strobe from Control
flush  out  1  pipeline flush (IF/ID/EX registers cleared)
pc_redirect  out  1  one-cycle strobe; PC loads redirect_pc
redirect_pc  out  PC_W  target address, valid when pc_redirect=1
epc  out  PC_W  latched exception PC
cause  out  CAUSE_W  index of the accepted source
exl  out  1  exception level; 1 while in FLUSH/REDIRECT/HANDLER
exc_lost  out  1  sticky; a request arrived while exl=1

Behaviour:
- Reset is synchronous and active-high. When rst=1 at a clk edge:
  - state goes to IDLE.
  - flush, pc_redirect, exl and exc_lost go to 0.
  - epc, redirect_pc and cause go to 0.
  - Reset overrides every other input, including mid-FLUSH or mid-HANDLER.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, FLUSH, REDIRECT, HANDLER.
- IDLE, when a (masked) exc_req is nonzero at edge T:
  - cause <= index of the lowest set bit.
  - epc <= exc_pc.
  - exl <= 1, flush <= 1, counter <= FLUSH_CYCLES-1.
  - Next state FLUSH.
  - Result: flush is high in cycles T+1 .. T+FLUSH_CYCLES.
- FLUSH:
  - Counter decrements each cycle.
  - At count 0: flush <= 0, pc_redirect <= 1, redirect_pc <= HANDLER_ADDR, next state REDIRECT.
- REDIRECT:
  - pc_redirect is high for exactly 1 cycle; it is cleared next cycle.
  - Next state HANDLER.
- HANDLER:
  - Holds until eret=1.
  - On eret: pc_redirect <= 1, redirect_pc <= epc, exl <= 0, exc_lost <= 0, next state IDLE.
  - The return redirect is seen one cycle after eret.
- Nested exceptions are not supported:
  - Any exc_req while exl=1 (FLUSH, REDIRECT or HANDLER) is ignored for capture.
  - It sets exc_lost <= 1, which stays set until eret or rst.
  - eret and exc_req in the same HANDLER cycle: eret wins; exc_lost is cleared, not set.
- eret in IDLE, FLUSH or REDIRECT is ignored.
- In IDLE, epc and cause hold the last accepted values.
- exc_req in the IDLE cycle immediately following an eret return is accepted normally (back-to-back).
- Multiple simultaneous requests: only the highest-priority one is recorded. No queueing.

Optional Feature:
Macro EXC_MASK_EN.
- When defined:
  - Adds input exc_mask [NUM_SRC] (1 = enabled), positioned after exc_pc.
  - The effective request is exc_req & exc_mask, for both capture and exc_lost.
  - Priority is computed on the masked vector.
- When undefined:
  - The port does not exist.
  - All sources are always enabled.

Test Plan:
1. rst=1 for 2 cycles during HANDLER -> next cycle state IDLE; flush=0, pc_redirect=0, exl=0, exc_lost=0, epc=0, cause=0.
2. IDLE, exc_req=5'b00100, exc_pc=32'h0040_0010 at edge T, FLUSH_CYCLES=2 -> cause=2, epc=32'h0040_0010 and flush=1 in T+1..T+2; pc_redirect=1 with redirect_pc=32'h8000_0180 at T+3; exl=1.
3. exc_req=5'b10110 in IDLE -> cause=1 (lowest set bit wins), exactly one flush sequence.
4. In HANDLER, exc_req=5'b00001 for one cycle -> exc_lost=1, epc/cause unchanged. Then eret=1 -> next cycle pc_redirect=1, redirect_pc=epc, exl=0, exc_lost=0.
5. eret=1 in IDLE and during FLUSH -> no pc_redirect, state sequence unchanged. eret and exc_req in the same HANDLER cycle -> return taken, exc_lost=0.
6. With EXC_MASK_EN defined, exc_mask=5'b11011, exc_req=5'b00100 -> no flush, state stays IDLE. Then exc_req=5'b00110 -> cause=1.
